// File: rtl/naive_bus_timer_if.sv
// naive_bus responder-side signal bundle: independent read and write channels
// with request/grant handshakes and byte-enabled writes.
interface naive_bus_timer_if;
    logic        rd_req;
    logic        rd_gnt;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        wr_req;
    logic        wr_gnt;
    logic [31:0] wr_addr;
    logic [3:0]  wr_byte_en;
    logic [31:0] wr_data;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_byte_en, wr_data,
        input  rd_gnt, rd_data, wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_byte_en, wr_data,
        output rd_gnt, rd_data, wr_gnt
    );
endinterface

// File: rtl/naive_bus_timer.sv
// Timer/compare peripheral on the naive_bus: prescaled 32-bit counter,
// compare match flag (W1C) and a registered level interrupt.
module naive_bus_timer #(
    parameter int          PRESCALE_W    = 16,
    parameter logic [31:0] RESET_COMPARE = 32'hffff_ffff
) (
    input  logic                   clk,
    input  logic                   rst,
    naive_bus_timer_if.slave       bus,
    output logic                   irq
);

    typedef enum logic [1:0] {
        REG_CTRL     = 2'd0,
        REG_PRESCALE = 2'd1,
        REG_COUNT    = 2'd2,
        REG_COMPARE  = 2'd3
    } reg_sel_e;

    logic                  enable_q,      enable_d;
    logic                  auto_reload_q, auto_reload_d;
    logic                  irq_en_q,      irq_en_d;
    logic                  flag_q,        flag_d;
    logic [PRESCALE_W-1:0] prescale_q,    prescale_d;
    logic [PRESCALE_W-1:0] pcnt_q,        pcnt_d;
    logic [31:0]           count_q,       count_d;
    logic [31:0]           compare_q,     compare_d;
    logic [31:0]           rd_data_q,     rd_data_d;
    logic                  irq_q,         irq_d;

    logic [31:0] reg_view [4];
    logic [31:0] prescale_ext;
    logic [31:0] wr_old;
    logic [31:0] wr_merged;
    logic [3:0]  wr_sel;
    logic        wr_active;
    logic        tick;
    reg_sel_e    rd_idx;
    reg_sel_e    wr_idx;

    // Address bits outside [3:2] are don't-care: the block aliases every 16 bytes.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.rd_addr[31:4], bus.rd_addr[1:0],
                                bus.wr_addr[31:4], bus.wr_addr[1:0]};

    assign rd_idx = reg_sel_e'(bus.rd_addr[3:2]);
    assign wr_idx = reg_sel_e'(bus.wr_addr[3:2]);

    assign bus.rd_gnt  = bus.rd_req;
    assign bus.wr_gnt  = bus.wr_req;
    assign bus.rd_data = rd_data_q;
    assign irq         = irq_q;

    always_comb begin
        prescale_ext                   = '0;
        prescale_ext[PRESCALE_W-1:0]   = prescale_q;
    end

    always_comb begin
        reg_view[REG_CTRL]     = {23'd0, flag_q, 5'd0, irq_en_q, auto_reload_q, enable_q};
        reg_view[REG_PRESCALE] = prescale_ext;
        reg_view[REG_COUNT]    = count_q;
        reg_view[REG_COMPARE]  = compare_q;
    end

    assign wr_old = reg_view[wr_idx];

    // A write with no byte enables is a no-op, so it must not count as a hit
    // (otherwise it would still clear the prescale counter).
    assign wr_active = bus.wr_req && (|bus.wr_byte_en);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wr
            assign wr_merged[8*gi +: 8] = bus.wr_byte_en[gi] ? bus.wr_data[8*gi +: 8]
                                                             : wr_old[8*gi +: 8];
            assign wr_sel[gi] = wr_active && (wr_idx == reg_sel_e'(gi));
        end
    endgenerate

    assign tick = enable_q && (pcnt_q == prescale_q);

    always_comb begin
        enable_d      = enable_q;
        auto_reload_d = auto_reload_q;
        irq_en_d      = irq_en_q;
        flag_d        = flag_q;
        prescale_d    = prescale_q;
        pcnt_d        = pcnt_q;
        count_d       = count_q;
        compare_d     = compare_q;
        rd_data_d     = rd_data_q;
        irq_d         = irq_q;

        if (wr_sel[REG_PRESCALE] || !enable_q || tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PRESCALE_W'(1);
        end

        if (wr_sel[REG_CTRL]) begin
            enable_d      = wr_merged[0];
            auto_reload_d = wr_merged[1];
            irq_en_d      = wr_merged[2];
            if (bus.wr_byte_en[1] && bus.wr_data[8]) begin
                flag_d = 1'b0;
            end
        end

        if (wr_sel[REG_PRESCALE]) begin
            prescale_d = wr_merged[PRESCALE_W-1:0];
        end

        if (wr_sel[REG_COMPARE]) begin
            compare_d = wr_merged;
        end

        // A bus write to COUNT suppresses both the increment and the match check;
        // a match sets the flag after any W1C above, so a simultaneous set wins.
        if (wr_sel[REG_COUNT]) begin
            count_d = wr_merged;
        end else if (tick) begin
            if (count_q == compare_q) begin
                flag_d  = 1'b1;
                count_d = auto_reload_q ? 32'd0 : count_q + 32'd1;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        irq_d = flag_d && irq_en_d;

        if (bus.rd_req) begin
            rd_data_d = reg_view[rd_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q      <= 1'b0;
            auto_reload_q <= 1'b0;
            irq_en_q      <= 1'b0;
            flag_q        <= 1'b0;
            prescale_q    <= '0;
            pcnt_q        <= '0;
            count_q       <= 32'd0;
            compare_q     <= RESET_COMPARE;
            rd_data_q     <= 32'd0;
            irq_q         <= 1'b0;
        end else begin
            enable_q      <= enable_d;
            auto_reload_q <= auto_reload_d;
            irq_en_q      <= irq_en_d;
            flag_q        <= flag_d;
            prescale_q    <= prescale_d;
            pcnt_q        <= pcnt_d;
            count_q       <= count_d;
            compare_q     <= compare_d;
            rd_data_q     <= rd_data_d;
            irq_q         <= irq_d;
        end
    end

endmodule

// File: tb/tb_naive_bus_timer.sv
// Directed bench for naive_bus_timer: read expectations are queued when a read
// is issued and popped when the registered read data appears.
module tb_naive_bus_timer;

    localparam logic [1:0] A_CTRL     = 2'd0;
    localparam logic [1:0] A_PRESCALE = 2'd1;
    localparam logic [1:0] A_COUNT    = 2'd2;
    localparam logic [1:0] A_COMPARE  = 2'd3;

    logic clk;
    logic rst;
    logic irq;

    int n_asserts;
    int n_fail;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    naive_bus_timer_if bus ();

    naive_bus_timer #(
        .PRESCALE_W    (16),
        .RESET_COMPARE (32'hffff_ffff)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .irq (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alias_addr(input logic [1:0] sel);
        logic [31:0] a;
        a      = $urandom();
        a[3:2] = sel;
        return a;
    endfunction

    // Drive a read, confirm the same-cycle grant, then compare next-cycle data.
    task automatic rd(input logic [1:0] sel, input logic [31:0] exp, input string tag);
        logic [31:0] e;
        string       t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus.rd_req  = 1'b1;
        bus.rd_addr = alias_addr(sel);
        #1;
        check({tag, "_gnt"}, {31'd0, bus.rd_gnt}, 32'd1);
        @(posedge clk);
        #1;
        bus.rd_req = 1'b0;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, bus.rd_data, e);
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] data, input logic [3:0] be);
        bus.wr_req     = 1'b1;
        bus.wr_addr    = alias_addr(sel);
        bus.wr_data    = data;
        bus.wr_byte_en = be;
        #1;
        check("wr_gnt", {31'd0, bus.wr_gnt}, 32'd1);
        @(posedge clk);
        #1;
        bus.wr_req     = 1'b0;
        bus.wr_byte_en = 4'd0;
    endtask

    // Read and write granted in the same cycle.
    task automatic rw(input logic [1:0] rsel, input logic [31:0] rexp, input string tag,
                      input logic [1:0] wsel, input logic [31:0] data, input logic [3:0] be);
        logic [31:0] e;
        string       t;
        exp_q.push_back(rexp);
        tag_q.push_back(tag);
        bus.rd_req     = 1'b1;
        bus.rd_addr    = alias_addr(rsel);
        bus.wr_req     = 1'b1;
        bus.wr_addr    = alias_addr(wsel);
        bus.wr_data    = data;
        bus.wr_byte_en = be;
        @(posedge clk);
        #1;
        bus.rd_req     = 1'b0;
        bus.wr_req     = 1'b0;
        bus.wr_byte_en = 4'd0;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, bus.rd_data, e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] seq4 [7];
        n_asserts      = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.rd_req     = 1'b0;
        bus.rd_addr    = 32'd0;
        bus.wr_req     = 1'b0;
        bus.wr_addr    = 32'd0;
        bus.wr_byte_en = 4'd0;
        bus.wr_data    = 32'd0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        idle(1);

        // Reset state
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rd_data", bus.rd_data, 32'd0);
        rd(A_CTRL,     32'h0000_0000, "rst_ctrl");
        rd(A_PRESCALE, 32'h0000_0000, "rst_prescale");
        rd(A_COUNT,    32'h0000_0000, "rst_count");
        rd(A_COMPARE,  32'hffff_ffff, "rst_compare");

        // Prescale 3: one tick per 4 cycles, 40 cycles -> 10
        wr(A_PRESCALE, 32'h0000_0003, 4'hf);
        rd(A_PRESCALE, 32'h0000_0003, "prescale_rb");
        wr(A_CTRL, 32'h0000_0001, 4'h1);
        idle(39);
        wr(A_CTRL, 32'h0000_0000, 4'h1);
        rd(A_COUNT, 32'd10, "presc_count");
        wr(A_CTRL, 32'h0000_0001, 4'h1);
        idle(3);
        rd(A_COUNT, 32'd10, "reen_before_tick");
        rd(A_COUNT, 32'd11, "reen_first_tick");
        wr(A_CTRL, 32'h0000_0000, 4'h1);

        // Compare match with auto-reload and irq
        wr(A_COUNT,    32'd0, 4'hf);
        wr(A_PRESCALE, 32'd0, 4'hf);
        wr(A_COMPARE,  32'd5, 4'hf);
        wr(A_CTRL, 32'h0000_0007, 4'h1);
        for (int i = 0; i < 7; i++) begin
            rd(A_COUNT, (i == 6) ? 32'd0 : 32'(i), $sformatf("match_count_%0d", i));
            check($sformatf("match_irq_%0d", i), {31'd0, irq}, (i >= 5) ? 32'd1 : 32'd0);
        end
        rd(A_CTRL, 32'h0000_0107, "match_ctrl");
        wr(A_CTRL, 32'h0000_0107, 4'h3);
        check("w1c_irq", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            rd(A_CTRL, 32'h0000_0007, $sformatf("w1c_ctrl_%0d", i));
        end
        rd(A_CTRL, 32'h0000_0107, "reflag_ctrl");
        check("reflag_irq", {31'd0, irq}, 32'd1);
        wr(A_CTRL, 32'h0000_0100, 4'h3);
        rd(A_CTRL, 32'h0000_0000, "clear_all_ctrl");

        // Wrap without auto-reload
        seq4[0] = 32'hffff_fffe; seq4[1] = 32'hffff_ffff; seq4[2] = 32'd0;
        seq4[3] = 32'd1; seq4[4] = 32'd2; seq4[5] = 32'd3; seq4[6] = 32'd4;
        wr(A_COUNT,   32'hffff_fffe, 4'hf);
        wr(A_COMPARE, 32'd3, 4'hf);
        wr(A_CTRL,    32'h0000_0001, 4'h1);
        for (int i = 0; i < 7; i++) begin
            rd(A_COUNT, seq4[i], $sformatf("wrap_count_%0d", i));
        end
        rd(A_CTRL, 32'h0000_0101, "wrap_ctrl");
        wr(A_CTRL, 32'h0000_0100, 4'h1);
        rd(A_CTRL, 32'h0000_0100, "be0_keeps_flag");
        wr(A_CTRL, 32'h0000_0000, 4'h3);
        rd(A_CTRL, 32'h0000_0100, "write0_keeps_flag");

        // COUNT write collides with a tick; read returns the old value
        wr(A_COUNT, 32'h0000_0010, 4'hf);
        wr(A_CTRL,  32'h0000_0001, 4'h1);
        rw(A_COUNT, 32'h0000_0010, "collide_old", A_COUNT, 32'h0000_0100, 4'hf);
        rd(A_COUNT, 32'h0000_0100, "collide_wins");
        rd(A_COUNT, 32'h0000_0101, "collide_next");
        wr(A_CTRL, 32'h0000_0100, 4'h3);
        rd(A_CTRL, 32'h0000_0000, "collide_ctrl");

        // Byte-lane write on COMPARE
        wr(A_COMPARE, 32'h12aa_3456, 4'h4);
        rd(A_COMPARE, 32'h00aa_0003, "byte_lane");
        wr(A_COMPARE, 32'd3, 4'hf);

        // Flag set and W1C in the same cycle: set wins
        wr(A_COUNT, 32'd2, 4'hf);
        wr(A_CTRL,  32'h0000_0101, 4'h3);
        idle(1);
        wr(A_CTRL,  32'h0000_0101, 4'h3);
        rd(A_CTRL,  32'h0000_0101, "set_beats_clear");
        wr(A_CTRL,  32'h0000_0101, 4'h3);
        rd(A_CTRL,  32'h0000_0001, "clear_after");
        wr(A_CTRL,  32'h0000_0000, 4'h1);

        // Asynchronous reset with irq high
        wr(A_COUNT,   32'd0, 4'hf);
        wr(A_COMPARE, 32'd2, 4'hf);
        wr(A_CTRL,    32'h0000_0007, 4'h1);
        idle(4);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        rd(A_COMPARE, 32'd2, "pre_rst_compare");
        #2 rst = 1'b1;
        #1;
        check("async_rst_irq", {31'd0, irq}, 32'd0);
        check("async_rst_rd_data", bus.rd_data, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        idle(10);
        rd(A_CTRL,     32'h0000_0000, "post_rst_ctrl");
        rd(A_PRESCALE, 32'h0000_0000, "post_rst_prescale");
        rd(A_COUNT,    32'h0000_0000, "post_rst_count");
        rd(A_COMPARE,  32'hffff_ffff, "post_rst_compare");
        idle(5);
        rd(A_COUNT,    32'h0000_0000, "post_rst_no_tick");
        check("post_rst_irq", {31'd0, irq}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
